// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StStall = 2'd2
  } state_e;

  localparam int unsigned REG_ZERO        = 0;
  localparam int unsigned DEFAULT_LEN     = 32;
  localparam int unsigned DEFAULT_NB_ADDR = 5;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the write-back stage / debug unit and the write-port arbiter.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned LEN     = DEFAULT_LEN,
  parameter int unsigned NB_ADDR = DEFAULT_NB_ADDR
) ();

  logic               i_wb_regwrite;
  logic [NB_ADDR-1:0] i_wb_addr;
  logic [LEN-1:0]     i_wb_data;
  logic               i_dbg_req;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [LEN-1:0]     i_dbg_data;

  logic               o_rf_we;
  logic [NB_ADDR-1:0] o_rf_addr;
  logic [LEN-1:0]     o_rf_data;
  logic               o_dbg_busy;
  logic               o_dbg_ack;
  logic               o_pipe_stall;
  logic               o_protocol_err;

  modport slave (
    input  i_wb_regwrite, i_wb_addr, i_wb_data, i_dbg_req, i_dbg_addr, i_dbg_data,
    output o_rf_we, o_rf_addr, o_rf_data, o_dbg_busy, o_dbg_ack, o_pipe_stall, o_protocol_err
  );

  modport master (
    output i_wb_regwrite, i_wb_addr, i_wb_data, i_dbg_req, i_dbg_addr, i_dbg_data,
    input  o_rf_we, o_rf_addr, o_rf_data, o_dbg_busy, o_dbg_ack, o_pipe_stall, o_protocol_err
  );

endinterface

// File: rtl/wb_port_arbiter_wait_counter.sv
// Saturating wait counter with synchronous clear and count enable.
module wb_port_arbiter_wait_counter
  import wb_port_arbiter_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX = CNT_W'(4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back wins, debug writes wait for a free slot
// and stall the front end after MAX_WAIT lost cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned LEN      = DEFAULT_LEN,
  parameter int unsigned NB_ADDR  = DEFAULT_NB_ADDR,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam logic [NB_ADDR-1:0] RegZero  = NB_ADDR'(REG_ZERO);
  localparam logic [CNT_W-1:0]   MaxCnt   = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]   StallAt  = CNT_W'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic               rf_we_q, rf_we_d;
  logic [NB_ADDR-1:0] rf_addr_q, rf_addr_d;
  logic [LEN-1:0]     rf_data_q, rf_data_d;
  logic [NB_ADDR-1:0] hold_addr_q, hold_addr_d;
  logic [LEN-1:0]     hold_data_q, hold_data_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               stall_q, stall_d;
  logic               err_q, err_d;
  logic               cnt_clr, cnt_en;
  logic [CNT_W-1:0]   cnt_q;

  wb_port_arbiter_wait_counter #(
    .MAX (MaxCnt)
  ) wait_counter (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_q)
  );

  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    stall_d     = stall_q;
    err_d       = err_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    // The pipeline always owns the port when it writes, whatever the state.
    if (bus.i_wb_regwrite) begin
      rf_we_d   = (bus.i_wb_addr != RegZero);
      rf_addr_d = bus.i_wb_addr;
      rf_data_d = bus.i_wb_data;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.i_dbg_req) begin
          hold_addr_d = bus.i_dbg_addr;
          hold_data_d = bus.i_dbg_data;
          busy_d      = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (bus.i_wb_regwrite) begin
          cnt_en = 1'b1;
          if (cnt_q == StallAt) begin
            state_d = StStall;
            stall_d = 1'b1;
          end
        end
      end
      StStall: begin
        if (bus.i_wb_regwrite) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        stall_d = 1'b0;
      end
    endcase

    // Free slot while a debug write is held: issue it and release the port.
    if ((state_q == StWait || state_q == StStall) && !bus.i_wb_regwrite) begin
      rf_we_d   = (hold_addr_q != RegZero);
      rf_addr_d = hold_addr_q;
      rf_data_d = hold_data_q;
      ack_d     = 1'b1;
      busy_d    = 1'b0;
      stall_d   = 1'b0;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_rf_we        = rf_we_q;
  assign bus.o_rf_addr      = rf_addr_q;
  assign bus.o_rf_data      = rf_data_q;
  assign bus.o_dbg_busy     = busy_q;
  assign bus.o_dbg_ack      = ack_q;
  assign bus.o_pipe_stall   = stall_q;
  assign bus.o_protocol_err = err_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: expected register-file writes are queued as stimulus
// is driven and compared as the port produces them.
module tb_wb_port_arbiter;

  localparam int unsigned LEN      = 32;
  localparam int unsigned NB_ADDR  = 5;
  localparam int unsigned MAX_WAIT = 4;

  typedef struct packed {
    logic [NB_ADDR-1:0] addr;
    logic [LEN-1:0]     data;
  } wr_t;

  logic i_clk;
  logic i_rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  exp_q[$];
  wr_t  exp_wr;
  wr_t  got_wr;

  wb_port_arbiter_if #(.LEN(LEN), .NB_ADDR(NB_ADDR)) bus ();

  wb_port_arbiter #(
    .LEN      (LEN),
    .NB_ADDR  (NB_ADDR),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic drive(input logic wb, input logic [NB_ADDR-1:0] waddr, input logic [LEN-1:0] wdata,
                       input logic dbg, input logic [NB_ADDR-1:0] daddr,
                       input logic [LEN-1:0] ddata);
    bus.i_wb_regwrite = wb;
    bus.i_wb_addr     = waddr;
    bus.i_wb_data     = wdata;
    bus.i_dbg_req     = dbg;
    bus.i_dbg_addr    = daddr;
    bus.i_dbg_data    = ddata;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6+NB_ADDR+LEN-1:0] outs;
    i_rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) cycle();
    outs = {bus.o_rf_we, bus.o_rf_addr, bus.o_rf_data, bus.o_dbg_busy, bus.o_dbg_ack,
            bus.o_pipe_stall, bus.o_protocol_err};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    i_rst_n = 1'b1;
    cycle();
    outs = {bus.o_rf_we, bus.o_rf_addr, bus.o_rf_data, bus.o_dbg_busy, bus.o_dbg_ack,
            bus.o_pipe_stall, bus.o_protocol_err};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h required 0", outs);
    end
  endtask

  task automatic test_idle_port();
    drive(0, 0, 0, 1, 5'd3, 32'hDEAD_BEEF);
    cycle();
    n_checks++;
    if ({bus.o_dbg_busy, bus.o_rf_we, bus.o_dbg_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_latch busy/we/ack: got %b required 100",
               {bus.o_dbg_busy, bus.o_rf_we, bus.o_dbg_ack});
    end
    drive(0, 0, 0, 0, 0, 0);
    exp_q.push_back('{addr: 5'd3, data: 32'hDEAD_BEEF});
    cycle();
    n_checks++;
    if ({bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL idle_issue we/ack/busy: got %b required 110",
               {bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy});
    end
    if (bus.o_rf_we && exp_q.size() != 0) begin
      exp_wr = exp_q.pop_front();
      got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
      n_checks++;
      if (got_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL idle_issue_write: got %h required %h", got_wr, exp_wr);
      end
    end
    cycle();
    n_checks++;
    if ({bus.o_rf_we, bus.o_dbg_ack, bus.o_rf_addr, bus.o_rf_data} !==
        {2'b00, 5'd3, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL idle_hold we/ack/addr/data: got %b %b %h %h required 0 0 03 deadbeef",
               bus.o_rf_we, bus.o_dbg_ack, bus.o_rf_addr, bus.o_rf_data);
    end
  endtask

  task automatic test_contention();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1, 5'd10, 32'hA0, 1, 5'd5, 32'h55);
          exp_q.push_back('{addr: 5'd10, data: 32'hA0});
        end
        1: begin
          drive(1, 5'd11, 32'hA1, 0, 0, 0);
          exp_q.push_back('{addr: 5'd11, data: 32'hA1});
        end
        default: begin
          drive(0, 0, 0, 0, 0, 0);
          exp_q.push_back('{addr: 5'd5, data: 32'h55});
        end
      endcase
      cycle();
      n_checks++;
      if ({bus.o_rf_we, bus.o_pipe_stall, bus.o_dbg_ack, bus.o_dbg_busy} !==
          {1'b1, 1'b0, (i == 2), (i != 2)}) begin
        n_fail++;
        $display("FAIL contention_ctl[%0d] we/stall/ack/busy: got %b required %b", i,
                 {bus.o_rf_we, bus.o_pipe_stall, bus.o_dbg_ack, bus.o_dbg_busy},
                 {1'b1, 1'b0, (i == 2), (i != 2)});
      end
      if (bus.o_rf_we && exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
        n_checks++;
        if (got_wr !== exp_wr) begin
          n_fail++;
          $display("FAIL contention_write[%0d]: got %h required %h", i, got_wr, exp_wr);
        end
      end
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        drive(0, 0, 0, 1, 5'd9, 32'h99);
      end else if (i < 5) begin
        drive(1, 5'(12 + i), 32'hB0 + i, 0, 0, 0);
        exp_q.push_back('{addr: 5'(12 + i), data: 32'hB0 + i});
      end else begin
        drive(0, 0, 0, 0, 0, 0);
        exp_q.push_back('{addr: 5'd9, data: 32'h99});
      end
      cycle();
      n_checks++;
      if ({bus.o_rf_we, bus.o_pipe_stall, bus.o_dbg_ack, bus.o_dbg_busy} !==
          {(i != 0), (i == 4), (i == 5), (i != 5)}) begin
        n_fail++;
        $display("FAIL starvation_ctl[%0d] we/stall/ack/busy: got %b required %b", i,
                 {bus.o_rf_we, bus.o_pipe_stall, bus.o_dbg_ack, bus.o_dbg_busy},
                 {(i != 0), (i == 4), (i == 5), (i != 5)});
      end
      if (bus.o_rf_we && exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
        n_checks++;
        if (got_wr !== exp_wr) begin
          n_fail++;
          $display("FAIL starvation_write[%0d]: got %h required %h", i, got_wr, exp_wr);
        end
      end
    end
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd0, 32'hCAFE, 0, 0, 0);
    cycle();
    n_checks++;
    if (bus.o_rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_wb_we: got %b required 0", bus.o_rf_we);
    end
    drive(0, 0, 0, 1, 5'd0, 32'h1234);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    n_checks++;
    if ({bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_dbg we/ack/busy: got %b required 010",
               {bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin
          drive(1, 5'd2, 32'h22, 1, 5'd1, 32'h11);
          exp_q.push_back('{addr: 5'd2, data: 32'h22});
        end
        1: begin
          drive(1, 5'd3, 32'h33, 1, 5'd20, 32'hBAD);
          exp_q.push_back('{addr: 5'd3, data: 32'h33});
        end
        2: begin
          drive(0, 0, 0, 1, 5'd21, 32'hBAD2);
          exp_q.push_back('{addr: 5'd1, data: 32'h11});
        end
        default: drive(0, 0, 0, 0, 0, 0);
      endcase
      cycle();
      n_checks++;
      if ({bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy} !== {(i < 3), (i == 2), (i < 2)}) begin
        n_fail++;
        $display("FAIL b2b_ctl[%0d] we/ack/busy: got %b required %b", i,
                 {bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy}, {(i < 3), (i == 2), (i < 2)});
      end
      if (bus.o_rf_we && exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
        n_checks++;
        if (got_wr !== exp_wr) begin
          n_fail++;
          $display("FAIL b2b_write[%0d]: got %h required %h", i, got_wr, exp_wr);
        end
      end
    end
  endtask

  task automatic test_protocol_err();
    n_checks++;
    if (bus.o_protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_initial: got %b required 0", bus.o_protocol_err);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        drive(0, 0, 0, 1, 5'd4, 32'h44);
      end else if (i < 5) begin
        drive(1, 5'(24 + i), 32'hC0 + i, 0, 0, 0);
        exp_q.push_back('{addr: 5'(24 + i), data: 32'hC0 + i});
      end else if (i == 5) begin
        drive(1, 5'd7, 32'h77, 0, 0, 0);
        exp_q.push_back('{addr: 5'd7, data: 32'h77});
      end else begin
        drive(0, 0, 0, 0, 0, 0);
        if (i == 6) exp_q.push_back('{addr: 5'd4, data: 32'h44});
      end
      cycle();
      n_checks++;
      if ({bus.o_rf_we, bus.o_pipe_stall, bus.o_protocol_err, bus.o_dbg_ack} !==
          {(i >= 1 && i <= 6), (i == 4 || i == 5), (i >= 5), (i == 6)}) begin
        n_fail++;
        $display("FAIL perr_ctl[%0d] we/stall/err/ack: got %b required %b", i,
                 {bus.o_rf_we, bus.o_pipe_stall, bus.o_protocol_err, bus.o_dbg_ack},
                 {(i >= 1 && i <= 6), (i == 4 || i == 5), (i >= 5), (i == 6)});
      end
      if (bus.o_rf_we && exp_q.size() != 0) begin
        exp_wr = exp_q.pop_front();
        got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
        n_checks++;
        if (got_wr !== exp_wr) begin
          n_fail++;
          $display("FAIL perr_write[%0d]: got %h required %h", i, got_wr, exp_wr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6+NB_ADDR+LEN-1:0] outs;
    drive(0, 0, 0, 1, 5'd6, 32'h66);
    cycle();
    drive(1, 5'd13, 32'hD13, 0, 0, 0);
    exp_q.push_back('{addr: 5'd13, data: 32'hD13});
    cycle();
    if (bus.o_rf_we && exp_q.size() != 0) begin
      exp_wr = exp_q.pop_front();
      got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
      n_checks++;
      if (got_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL rmid_write: got %h required %h", got_wr, exp_wr);
      end
    end
    n_checks++;
    if (bus.o_dbg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_busy_before: got %b required 1", bus.o_dbg_busy);
    end
    // Assert reset between clock edges so only the asynchronous path can clear outputs.
    #2;
    i_rst_n = 1'b0;
    #1;
    outs = {bus.o_rf_we, bus.o_rf_addr, bus.o_rf_data, bus.o_dbg_busy, bus.o_dbg_ack,
            bus.o_pipe_stall, bus.o_protocol_err};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rmid_async_clear: got %h required 0", outs);
    end
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    #2;
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rmid_no_ack[%0d] we/ack/busy: got %b required 000", i,
                 {bus.o_rf_we, bus.o_dbg_ack, bus.o_dbg_busy});
      end
    end
    drive(0, 0, 0, 1, 5'd8, 32'h88);
    cycle();
    n_checks++;
    if (bus.o_dbg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_new_req_busy: got %b required 1", bus.o_dbg_busy);
    end
    drive(0, 0, 0, 0, 0, 0);
    exp_q.push_back('{addr: 5'd8, data: 32'h88});
    cycle();
    n_checks++;
    if ({bus.o_rf_we, bus.o_dbg_ack} !== 2'b11) begin
      n_fail++;
      $display("FAIL rmid_new_req_issue we/ack: got %b required 11",
               {bus.o_rf_we, bus.o_dbg_ack});
    end
    if (bus.o_rf_we && exp_q.size() != 0) begin
      exp_wr = exp_q.pop_front();
      got_wr = '{addr: bus.o_rf_addr, data: bus.o_rf_data};
      n_checks++;
      if (got_wr !== exp_wr) begin
        n_fail++;
        $display("FAIL rmid_new_req_write: got %h required %h", got_wr, exp_wr);
      end
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_idle_port();
    test_contention();
    test_starvation();
    test_zero_reg();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending writes required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter LEN, default 32, data width of a register-file write.
REQ-002 Parameter NB_ADDR, default 5, register address width.
REQ-003 Parameter MAX_WAIT, default 4, number of cycles a debug write waits for an idle write-back slot before the pipeline is stalled; range 1..15.
REQ-004 The block SHALL have one clock, i_clk; reset is asynchronous and active-low, named i_rst_n.
REQ-005 i_clk  in  1  rising-edge clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_wb_regwrite  in  1  write-back stage requests a register write this cycle.
REQ-008 i_wb_addr  in  NB_ADDR  write-back destination register.
REQ-009 i_wb_data  in  LEN  write-back data.
REQ-010 i_dbg_req  in  1  debug unit requests a register write (single-cycle pulse).
REQ-011 i_dbg_addr  in  NB_ADDR  debug destination register, sampled with i_dbg_req.
REQ-012 i_dbg_data  in  LEN  debug data, sampled with i_dbg_req.
REQ-013 o_rf_we  out  1  register-file write enable.
REQ-014 o_rf_addr  out  NB_ADDR  register-file write address.
REQ-015 o_rf_data  out  LEN  register-file write data.
REQ-016 o_dbg_busy  out  1  debug request held; new i_dbg_req ignored.
REQ-017 o_dbg_ack  out  1  one-cycle pulse: held debug write issued to the register file.
REQ-018 o_pipe_stall  out  1  freeze request to the pipeline front end.
REQ-019 o_protocol_err  out  1  sticky: pipeline wrote while stalled.

Function
REQ-020 All outputs SHALL be registered; o_rf_* SHALL appear exactly one cycle after the winning source is sampled.
REQ-021 States SHALL be IDLE, WAIT, STALL.
REQ-022 IDLE: i_dbg_req=1 SHALL latch addr/data into a holding register, set o_dbg_busy, clear the wait counter, and go to WAIT.
REQ-023 i_dbg_req while o_dbg_busy=1 SHALL be ignored; the holding register is unchanged.
REQ-024 Pipeline write-back SHALL always have priority; i_wb_regwrite=1 SHALL be forwarded to o_rf_* in every state.
REQ-025 WAIT or STALL with i_wb_regwrite=0: the held debug write SHALL be issued on o_rf_*, o_dbg_ack pulses in the same output cycle, o_dbg_busy and o_pipe_stall clear, and the state returns to IDLE.
REQ-026 WAIT with i_wb_regwrite=1: the wait counter SHALL increment; when it reaches MAX_WAIT the state SHALL go to STALL and o_pipe_stall SHALL be set.
REQ-027 Pipeline contract: the cycle after o_pipe_stall rises, i_wb_regwrite is 0.
REQ-028 STALL with i_wb_regwrite=1 SHALL forward the pipeline write (no data loss), set o_protocol_err, and remain in STALL.
REQ-029 A write to register 0 from either source SHALL produce o_rf_we=0; a debug write to register 0 SHALL still be acknowledged and release the port.
REQ-030 When neither source writes, o_rf_we SHALL be 0 and o_rf_addr/o_rf_data SHALL hold their previous values.
REQ-031 i_dbg_req in the same cycle as the issue of a held request SHALL be ignored; the request is accepted only in IDLE.
REQ-032 The wait counter SHALL saturate at MAX_WAIT; its width is 4 bits.

Reset
REQ-033 i_rst_n=0 SHALL force IDLE, counter 0, holding register 0, and all outputs 0, regardless of i_clk.
REQ-034 A held debug request SHALL be discarded by reset, with no o_dbg_ack.
REQ-035 Deassertion SHALL take effect at the first rising i_clk after i_rst_n=1.

Structure
REQ-036 A shared package SHALL define the state encoding (IDLE=2'd0, WAIT=2'd1, STALL=2'd2), REG_ZERO=0, and the default LEN/NB_ADDR.
REQ-037 The wait counter SHALL be one sub-module, wait_counter: saturating, with clear and enable.

Verification
REQ-038 Idle port: dbg_req addr=3 data=0xDEADBEEF, wb_regwrite=0 -> o_rf_we=1, addr 3, data 0xDEADBEEF, o_dbg_ack pulses 2 cycles after req.
REQ-039 Contention: dbg_req addr=5 with wb_regwrite=1 for 2 cycles, then 0 -> pipeline writes pass through unchanged; debug write issued in the third cycle; o_pipe_stall never set.
REQ-040 Starvation (MAX_WAIT=4): wb_regwrite=1 continuously -> o_pipe_stall set after 4 busy cycles; bench drops wb_regwrite -> debug issued, ack, stall clears.
REQ-041 Zero register: wb write addr 0 -> o_rf_we=0; dbg write addr 0 -> o_rf_we=0, o_dbg_ack=1.
REQ-042 Protocol violation: in STALL, wb_regwrite=1 addr 7 -> write forwarded, o_protocol_err=1 and held until reset.
REQ-043 Reset mid-operation: i_rst_n=0 in WAIT -> all outputs 0 asynchronously; no ack after release; a new dbg_req is accepted.
